imem_loader: RTL

//  Writer side of the instruction memory. Receives a program image as a byte stream (valid/ready) and emits

---
 rtl/imem_loader_pkg.sv | 7 +
 rtl/imem_loader_byte_packer.sv | 27 ++
 rtl/imem_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and sizes for the instruction-memory loader.
package imem_loader_pkg;
  localparam int IMEM_WORD_W    = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_DEPTH     = 64;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE} state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
module byte_packer import imem_loader_pkg::*; (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_byte_en,
  input  logic [7:0]             i_byte,
  output logic [IMEM_WORD_W-1:0] o_word,
  output logic                   o_word_valid
);
  logic [1:0]             r_idx;
  logic [IMEM_WORD_W-9:0] r_low;
  // bytes shift in from the top so the first byte ends up in bits [7:0]
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_low <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
      r_low <= '0;
    end else if (i_byte_en) begin
      r_idx <= r_idx + 2'd1;
      r_low <= {i_byte, r_low[IMEM_WORD_W-9:8]};
    end
  assign o_word_valid = i_byte_en && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_low};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader writing words into instruction memory.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader import imem_loader_pkg::*; #(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
  localparam int CW = $clog2(DEPTH + 1);
  state_t                 r_state;
  logic [7:0]             r_len_lo;
  logic [CW-1:0]          r_n, r_cnt;
  logic                   r_wr_en, r_err;
  logic [31:0]            r_wr_addr, r_wr_data;
  logic                   w_acc, w_bad, w_last, w_word_valid;
  logic [15:0]            w_n;
  logic [IMEM_WORD_W-1:0] w_word;
  assign in_ready = r_state inside {LEN_LO, LEN_HI, DATA, CHK};
  assign w_acc    = in_valid && in_ready;
  assign w_n      = {in_data, r_len_lo};
  assign w_bad    = (w_n == 16'd0) || ({16'd0, w_n} > 32'(DEPTH));
  assign w_last   = w_word_valid && ((r_cnt + CW'(1)) == r_n);
  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .i_clr        (w_acc && r_state == LEN_HI),
    .i_byte_en    (w_acc && r_state == DATA),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_csum <= '0;
    else if (w_acc && r_state == LEN_HI) r_csum <= '0;
    else if (w_acc && r_state == DATA) r_csum <= r_csum ^ in_data;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_len_lo  <= '0;
      r_n       <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= BASE_ADDR;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_word_valid;
      if (w_word_valid) begin
        r_wr_data <= w_word;
        r_wr_addr <= BASE_ADDR + 32'(r_cnt) * 32'(BYTES_PER_WORD);
        r_cnt     <= r_cnt + CW'(1);
      end
      case (r_state)
        IDLE, DONE: if (load_start) begin
          r_state <= LEN_LO;
          r_err   <= 1'b0;
        end
        LEN_LO: if (w_acc) begin
          r_len_lo <= in_data;
          r_state  <= LEN_HI;
        end
        LEN_HI: if (w_acc) begin
          r_n     <= CW'(w_n);
          r_cnt   <= '0;
          r_err   <= w_bad;
          r_state <= w_bad ? DONE : DATA;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        DATA: if (w_last) r_state <= CHK;
        CHK: if (w_acc) begin
          r_err   <= in_data != r_csum;
          r_state <= DONE;
        end
`else
        DATA: if (w_last) r_state <= DONE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign done     = r_state == DONE;
  assign cpu_hold = r_state != DONE;
  assign err      = r_err;
endmodule
